// File: rtl/fpu_mul_result_buffer.sv
// fpu_mul_result_buffer: circular FIFO holding half-precision products until writeback accepts them
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_res, i_res_vld, i_ovf, i_rd   product, valid, overflow flag and destination tag from the multiplier
//   o_in_rdy                        buffer can accept a product this cycle (= !o_full)
//   o_wb_data/rd/ovf/vld, i_wb_rdy  head entry toward writeback with its handshake
//   o_count, o_full, o_empty        occupancy status
//   o_drop_cnt                      saturating count of products offered while full
//   i_exc_clr, o_exc_sticky         sticky overflow flag (only built with FPU_EXC_STICKY_EN)
module fpu_mul_result_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [15:0]                i_res,
    input  logic                       i_res_vld,
    input  logic                       i_ovf,
    input  logic [TAG_W-1:0]           i_rd,
    output logic                       o_in_rdy,
    output logic [15:0]                o_wb_data,
    output logic [TAG_W-1:0]           o_wb_rd,
    output logic                       o_wb_ovf,
    output logic                       o_wb_vld,
    input  logic                       i_wb_rdy,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [7:0]                 o_drop_cnt,
    input  logic                       i_exc_clr,
    output logic                       o_exc_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] rd;
        logic             ovf;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          push, pop;

    assign o_full   = (count_q == CW'(DEPTH));
    assign o_empty  = (count_q == '0);
    assign o_in_rdy = !o_full;
    assign o_wb_vld = !o_empty;
    assign o_count  = count_q;
    assign o_drop_cnt = drop_q;
    assign o_wb_data = o_empty ? 16'h0 : mem_q[rd_ptr_q].res;
    assign o_wb_rd   = o_empty ? '0 : mem_q[rd_ptr_q].rd;
    assign o_wb_ovf  = o_empty ? 1'b0 : mem_q[rd_ptr_q].ovf;

    always_comb begin
        push = i_res_vld && o_in_rdy;
        pop  = o_wb_vld && i_wb_rdy;
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{res: i_res, rd: i_rd, ovf: i_ovf};
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        drop_d   = (i_res_vld && !o_in_rdy && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

`ifdef FPU_EXC_STICKY_EN
    logic exc_q, exc_d;

    // a new overflow takes priority over a clear in the same cycle
    always_comb exc_d = (push && i_ovf) ? 1'b1 : (i_exc_clr ? 1'b0 : exc_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) exc_q <= 1'b0;
        else exc_q <= exc_d;
    end

    assign o_exc_sticky = exc_q;
`else
    logic unused_exc_clr;

    assign unused_exc_clr = i_exc_clr;
    assign o_exc_sticky   = 1'b0;
`endif
endmodule
